// File: rtl/display.sv
// Purpose: credit accumulator plus 4-digit multiplexed seven-segment driver showing DD.CC dollars.
// Latency: balance updates 1 cycle after a coin edge; an/seg follow the digit select 1 cycle later.
// Backpressure: none; coin strobes are accepted every cycle and the balance saturates at MAX_CENTS.
module display #(
  parameter int SCAN_BITS = 18,
  parameter int MAX_CENTS = 9995
) (
  input  logic       clk_fast,
  input  logic       rst_n,
  input  logic       clk_blink,
  input  logic       dollar,
  input  logic       quarter,
  input  logic       dime,
  input  logic       nickel,
  input  logic       credit,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam logic [14:0] MAX_C15 = 15'(MAX_CENTS);

  logic [13:0]          balance;
  logic [3:0]           coin_q;
  logic [3:0]           coin_edge;
  logic [14:0]          added;
  logic [14:0]          sum_w;
  logic [13:0]          balance_next;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [1:0]           sel;
  logic                 blink_s1;
  logic                 blink_s2;
  logic                 blank;
  logic [3:0]           d3, d2, d1, d0;
  logic [3:0]           an_w;
  logic [7:0]           seg_w;

  // Active-low segment pattern for one decimal digit, dp off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Delay coins by one cycle so a held level is counted only on its rising edge.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) coin_q <= 4'b0000;
    else        coin_q <= {dollar, quarter, dime, nickel};
  end

  assign coin_edge = {dollar, quarter, dime, nickel} & ~coin_q;

  // Sum every coin edge seen this cycle and clamp the new balance at the limit.
  always_comb begin
    added = 15'd0;
    if (coin_edge[3]) added = added + 15'd100;
    if (coin_edge[2]) added = added + 15'd25;
    if (coin_edge[1]) added = added + 15'd10;
    if (coin_edge[0]) added = added + 15'd5;
    sum_w        = 15'(balance) + added;
    balance_next = (sum_w > MAX_C15) ? 14'(MAX_C15) : sum_w[13:0];
  end

  // Balance register.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) balance <= 14'd0;
    else        balance <= balance_next;
  end

  // Decimal digits of the balance: tens of dollars, dollars, dimes, cents.
  always_comb begin
    d3 = 4'(balance / 14'd1000);
    d2 = 4'((balance / 14'd100) % 14'd10);
    d1 = 4'((balance / 14'd10) % 14'd10);
    d0 = 4'(balance % 14'd10);
  end

  // Free-running refresh counter; its top two bits pick the active digit.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) scan_cnt <= '0;
    else        scan_cnt <= scan_cnt + 1'b1;
  end

  assign sel = scan_cnt[SCAN_BITS-1:SCAN_BITS-2];

  // Two-flop synchroniser for the slow blink wave, which is asynchronous data here.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      blink_s1 <= 1'b0;
      blink_s2 <= 1'b0;
    end else begin
      blink_s1 <= clk_blink;
      blink_s2 <= blink_s1;
    end
  end

  assign blank = credit & blink_s2;

  // Anode and segment pattern for the selected digit; the dollars digit carries the point.
  always_comb begin
    an_w  = 4'b1111;
    seg_w = 8'hFF;
    case (sel)
      2'd0: begin an_w = 4'b1110; seg_w = seg_code(d0); end
      2'd1: begin an_w = 4'b1101; seg_w = seg_code(d1); end
      2'd2: begin an_w = 4'b1011; seg_w = seg_code(d2) & 8'h7F; end
      default: begin
        an_w  = 4'b0111;
        seg_w = (d3 == 4'd0) ? 8'hFF : seg_code(d3);
      end
    endcase
  end

  // Registered pin drivers; blink mode darkens the whole display.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else if (blank) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= an_w;
      seg <= seg_w;
    end
  end

endmodule

// File: tb/tb_display.sv
// Directed bench for the credit display with a 4-bit refresh counter.
// Each digit stays active 4 cycles, so a 20-cycle sweep sees every digit.
// Outputs are sampled on the falling clock edge.
module tb_display;

  logic       clk_fast = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_blink = 1'b0;
  logic       dollar = 1'b0;
  logic       quarter = 1'b0;
  logic       dime = 1'b0;
  logic       nickel = 1'b0;
  logic       credit = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;

  int tests = 0;
  int fails = 0;
  logic [7:0] dig [4];
  int bad;

  display #(.SCAN_BITS(4), .MAX_CENTS(9995)) dut (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .clk_blink(clk_blink),
    .dollar   (dollar),
    .quarter  (quarter),
    .dime     (dime),
    .nickel   (nickel),
    .credit   (credit),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_fast);
  endtask

  // Capture the segment pattern shown for each anode over a full scan.
  task automatic sweep();
    for (int k = 0; k < 4; k++) dig[k] = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_fast);
      case (an)
        4'b1110: dig[0] = seg;
        4'b1101: dig[1] = seg;
        4'b1011: dig[2] = seg;
        4'b0111: dig[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic check_digits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                              input logic [7:0] e1, input logic [7:0] e0);
    sweep();
    check({tag, "_d3"}, dig[3], e3);
    check({tag, "_d2"}, dig[2], e2);
    check({tag, "_d1"}, dig[1], e1);
    check({tag, "_d0"}, dig[0], e0);
  endtask

  // Mid-cycle asynchronous reset pulse, then wait for the scan to restart.
  task automatic async_reset();
    @(negedge clk_fast);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", {4'h0, an}, 8'h0F);
    check("arst_seg", seg, 8'hFF);
    @(negedge clk_fast);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held low: display dark.
    cycles(3);
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", seg, 8'hFF);
    rst_n = 1'b1;
    check_digits("zero", 8'hFF, 8'h40, 8'hC0, 8'hC0);

    // 25 + 10 + 5 (nickel held 20 cycles counts once) = 40.
    quarter = 1'b1; cycles(1); quarter = 1'b0; cycles(2);
    dime = 1'b1;    cycles(1); dime = 1'b0;    cycles(2);
    nickel = 1'b1;  cycles(20); nickel = 1'b0; cycles(2);
    check_digits("c40", 8'hFF, 8'h40, 8'h99, 8'hC0);

    // Blink: credit=1, blanked while synced clk_blink is high.
    credit = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      clk_blink = ~clk_blink;
      cycles(3);
      bad = 0;
      for (int i = 0; i < 47; i++) begin
        @(negedge clk_fast);
        if (clk_blink) begin
          if (an !== 4'b1111 || seg !== 8'hFF) bad++;
        end else begin
          if (an === 4'b1111) bad++;
        end
      end
      check(clk_blink ? "blink_hi_blank" : "blink_lo_normal", 8'(bad), 8'd0);
    end
    // credit=0 with clk_blink high: never blank.
    credit = 1'b0;
    clk_blink = 1'b1;
    cycles(3);
    bad = 0;
    for (int i = 0; i < 47; i++) begin
      @(negedge clk_fast);
      if (an === 4'b1111) bad++;
    end
    check("nocredit_normal", 8'(bad), 8'd0);
    clk_blink = 1'b0;
    check_digits("c40_after_blink", 8'hFF, 8'h40, 8'h99, 8'hC0);

    // Asynchronous reset mid-scan clears balance.
    cycles(5);
    async_reset();
    check_digits("arst_zero", 8'hFF, 8'h40, 8'hC0, 8'hC0);

    // Dollar and quarter in the same cycle: 125.
    dollar = 1'b1; quarter = 1'b1; cycles(1);
    dollar = 1'b0; quarter = 1'b0; cycles(2);
    check_digits("c125", 8'hFF, 8'h79, 8'hA4, 8'h92);

    // Saturation: 100 dollars from zero caps at 9995.
    async_reset();
    for (int i = 0; i < 100; i++) begin
      dollar = 1'b1; cycles(1); dollar = 1'b0; cycles(1);
    end
    cycles(2);
    check_digits("sat", 8'h90, 8'h10, 8'h90, 8'h92);
    nickel = 1'b1; cycles(1); nickel = 1'b0; cycles(2);
    check_digits("sat_nickel", 8'h90, 8'h10, 8'h90, 8'h92);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
